// File: rtl/result_tx_sequencer.sv
// Converts a 16-bit magnitude plus sign into ASCII decimal text and streams it
// byte by byte into the UART transmitter, optionally followed by CR LF.
module result_tx_sequencer #(
  parameter int APPEND_CRLF = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        negative,
  output logic        busy,
  output logic        done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_LOAD, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_SIGN, PH_DIGIT, PH_CR, PH_LF, PH_END
  } phase_t;

  state_t      state;
  phase_t      phase;
  logic [15:0] shift_reg;
  logic [19:0] bcd;
  logic [19:0] bcd_adj;
  logic        neg_q;
  logic [3:0]  cnt;
  logic [2:0]  idx;
  logic        suppress;
  logic [3:0]  cur_digit;

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign cur_digit = bcd[{idx, 2'b00} +: 4];

  // Gated by tx_busy in the same cycle so a pulse can never overlap a busy UART.
  assign tx_start = (state == S_ISSUE) && !tx_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      phase     <= PH_SIGN;
      shift_reg <= '0;
      bcd       <= '0;
      neg_q     <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      suppress  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tx_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shift_reg <= value;
            neg_q     <= negative;
            bcd       <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          {bcd, shift_reg} <= {bcd_adj[18:0], shift_reg, 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            idx      <= 3'd4;
            suppress <= 1'b1;
            phase    <= neg_q ? PH_SIGN : PH_DIGIT;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          case (phase)
            PH_SIGN: begin
              tx_data <= 8'h2D;
              phase   <= PH_DIGIT;
              state   <= S_ISSUE;
            end
            PH_DIGIT: begin
              if (suppress && cur_digit == 4'd0 && idx != 3'd0) begin
                idx <= idx - 3'd1;
              end else begin
                tx_data  <= 8'h30 + {4'h0, cur_digit};
                suppress <= 1'b0;
                state    <= S_ISSUE;
                if (idx == 3'd0) phase <= (APPEND_CRLF != 0) ? PH_CR : PH_END;
                else idx <= idx - 3'd1;
              end
            end
            PH_CR: begin
              tx_data <= 8'h0D;
              phase   <= PH_LF;
              state   <= S_ISSUE;
            end
            PH_LF: begin
              tx_data <= 8'h0A;
              phase   <= PH_END;
              state   <= S_ISSUE;
            end
            default: begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          endcase
        end
        S_ISSUE:   if (!tx_busy) state <= S_WAIT_HI;
        S_WAIT_HI: if (tx_busy)  state <= S_WAIT_LO;
        S_WAIT_LO: if (!tx_busy) state <= S_LOAD;
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Table-driven bench for result_tx_sequencer with a simple UART busy model;
// one instance appends CR LF, a second sends digits only.
module tb_result_tx_sequencer;

  localparam int BUSY_LEN = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = '0;
  logic        negative = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic        busy1, done1, txs1, busy2, done2, txs2;
  logic [7:0]  txd1, txd2;
  logic        txb1, txb2;
  logic        force1 = 1'b0;

  int ucnt1 = 0, ucnt2 = 0;
  int ncyc = 0;
  int d1 = 0, d2 = 0;
  int first1 = 0, first2 = 0;
  int viol = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  int checks = 0;
  int failures = 0;

  result_tx_sequencer #(.APPEND_CRLF(1)) dut (
    .clk(clk), .reset(reset), .start(start1), .value(value), .negative(negative),
    .busy(busy1), .done(done1), .tx_start(txs1), .tx_data(txd1), .tx_busy(txb1)
  );

  result_tx_sequencer #(.APPEND_CRLF(0)) dut_nc (
    .clk(clk), .reset(reset), .start(start2), .value(value), .negative(negative),
    .busy(busy2), .done(done2), .tx_start(txs2), .tx_data(txd2), .tx_busy(txb2)
  );

  always #5 clk = ~clk;

  assign txb1 = force1 || (ucnt1 != 0);
  assign txb2 = (ucnt2 != 0);

  // UART model: busy rises the cycle after tx_start and lasts BUSY_LEN cycles.
  always @(posedge clk) begin
    ncyc <= ncyc + 1;
    if (txs1) ucnt1 <= BUSY_LEN; else if (ucnt1 != 0) ucnt1 <= ucnt1 - 1;
    if (txs2) ucnt2 <= BUSY_LEN; else if (ucnt2 != 0) ucnt2 <= ucnt2 - 1;
  end

  always @(negedge clk) begin
    if (txs1) begin
      if (txb1) viol++;
      if (q1.size() == 0) first1 = ncyc;
      q1.push_back(txd1);
    end
    if (txs2) begin
      if (txb2) viol++;
      if (q2.size() == 0) first2 = ncyc;
      q2.push_back(txd2);
    end
    if (done1) d1++;
    if (done2) d2++;
  end

  typedef struct {
    logic        sel;
    logic [15:0] value;
    logic        neg;
    int          n;
    logic [63:0] bytes;
    int          lat;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int s0;
    int t;
    int n;
    logic [31:0] b;
    q1.delete(); q2.delete(); d1 = 0; d2 = 0;
    tick();
    value = v.value; negative = v.neg;
    if (v.sel) start2 = 1'b1; else start1 = 1'b1;
    s0 = ncyc;
    tick();
    start1 = 1'b0; start2 = 1'b0;
    check($sformatf("v%0d_busy_rise", k), v.sel ? busy2 : busy1, 1);
    t = 0;
    while (((v.sel ? d2 : d1) == 0) && t < 4000) begin
      tick();
      t++;
    end
    check($sformatf("v%0d_done_seen", k), v.sel ? d2 : d1, 1);
    tick();
    check($sformatf("v%0d_busy_fall", k), v.sel ? busy2 : busy1, 0);
    repeat (20) tick();
    check($sformatf("v%0d_single_done", k), v.sel ? d2 : d1, 1);
    n = v.sel ? q2.size() : q1.size();
    check($sformatf("v%0d_byte_count", k), n, v.n);
    for (int i = 0; i < v.n; i++) begin
      if (i < n) b = {24'h0, (v.sel ? q2[i] : q1[i])};
      else b = 32'hFFFF_FFFF;
      check($sformatf("v%0d_byte%0d", k, i), b, {24'h0, v.bytes[63-8*i -: 8]});
    end
    check($sformatf("v%0d_latency", k), (v.sel ? first2 : first1) - s0, v.lat);
  endtask

  initial begin
    int t;
    int rel;
    vec_t v42;

    vt[0] = '{1'b0, 16'd12345, 1'b0, 7, 64'h3132_3334_350D_0A00, 18};
    vt[1] = '{1'b0, 16'd0,     1'b0, 3, 64'h300D_0A00_0000_0000, 22};
    vt[2] = '{1'b0, 16'd65535, 1'b1, 8, 64'h2D36_3535_3335_0D0A, 18};
    vt[3] = '{1'b1, 16'd7,     1'b0, 1, 64'h3700_0000_0000_0000, 22};
    vt[4] = '{1'b0, 16'd0,     1'b1, 4, 64'h2D30_0D0A_0000_0000, 18};
    vt[5] = '{1'b0, 16'd100,   1'b0, 5, 64'h3130_300D_0A00_0000, 20};
    vt[6] = '{1'b1, 16'd9,     1'b1, 2, 64'h2D39_0000_0000_0000, 18};
    vt[7] = '{1'b1, 16'd10000, 1'b0, 5, 64'h3130_3030_3000_0000, 18};
    vt[8] = '{1'b1, 16'd65535, 1'b0, 5, 64'h3635_3533_3500_0000, 18};
    v42   = '{1'b0, 16'd42,    1'b0, 4, 64'h3432_0D0A_0000_0000, 21};

    repeat (3) tick();
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_tx_start", txs1, 0);
    check("rst_tx_data", txd1, 0);
    check("rst_nc_busy", busy2, 0);
    reset = 1'b1;
    repeat (2) tick();

    for (int k = 0; k < 9; k++) run_vec(vt[k], k);

    // UART held busy before the first byte, then a second start mid-message.
    q1.delete(); d1 = 0;
    force1 = 1'b1;
    tick();
    value = 16'd12345; negative = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (40) tick();
    check("held_no_tx", q1.size(), 0);
    @(posedge clk);
    #1;
    force1 = 1'b0;
    rel = ncyc;
    t = 0;
    while (q1.size() < 3 && t < 2000) begin tick(); t++; end
    check("held_reached_byte3", q1.size(), 3);
    check("held_first_after_release", first1, rel);
    value = 16'd999; negative = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    t = 0;
    while (d1 == 0 && t < 4000) begin tick(); t++; end
    repeat (60) tick();
    check("held_single_done", d1, 1);
    check("held_count", q1.size(), 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("held_byte%0d", i), (i < q1.size()) ? {24'h0, q1[i]} : 32'hFFFF_FFFF,
            {24'h0, vt[0].bytes[63-8*i -: 8]});

    // Reset during the third byte aborts the message.
    q1.delete(); d1 = 0;
    tick();
    value = 16'd12345; negative = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    t = 0;
    while (q1.size() < 3 && t < 2000) begin tick(); t++; end
    check("rst_mid_reached_byte3", q1.size(), 3);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_mid_tx_start", txs1, 0);
    check("rst_mid_busy", busy1, 0);
    check("rst_mid_done", done1, 0);
    repeat (3) tick();
    reset = 1'b1;
    t = 0;
    while (txb1 && t < 200) begin tick(); t++; end
    check("rst_mid_uart_idle", txb1, 0);
    repeat (10) tick();
    check("rst_mid_no_more_bytes", q1.size(), 3);
    check("rst_mid_no_done", d1, 0);
    run_vec(v42, 9);

    check("no_start_while_busy", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_tx_sequencer.md
Name: result_tx_sequencer

Overview:
- Converts a 16-bit unsigned calculator result, plus a sign flag, into ASCII decimal text.
- Streams the text byte by byte through the existing UART transmitter, optionally followed by CR LF.
- Sits between the calculator result path and the UART transmitter. It is the only source of the transmitter's start and data inputs.

Parameters:
APPEND_CRLF, 1, when 1 append 0x0D then 0x0A after the digits; when 0 send digits only.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  request to send; sampled only in IDLE
value  input  16  unsigned magnitude to print (0..65535)
negative  input  1  when 1, prefix the text with '-' (0x2D)
busy  output  1  high from the cycle after start is accepted until the cycle after done
done  output  1  one-cycle pulse after the last byte's transmission completes
tx_start  output  1  to UART txdStart; one-cycle pulse per byte
tx_data  output  8  to UART data; valid and stable in the cycle tx_start is high
tx_busy  input  1  from UART txdBusy

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; busy=0, done=0, tx_start=0, tx_data=0x00; BCD and shift registers cleared.
- Reset mid-operation aborts the current message. No further tx_start is issued, and the UART completes its current byte on its own.
- IDLE: when start=1, latch value and negative, clear five 4-bit BCD digits, and go to CONVERT. A start outside IDLE is ignored; no queueing.
- CONVERT: sequential double-dabble, 16 cycles, one bit per cycle, MSB first.
  - Each cycle: add 3 to any BCD digit that is >=5, then shift left by one with the next value bit entering.
  - Result: digits D4..D0, where D4 is the ten-thousands digit.
  - Then go to LOAD, with the digit index at D4 and leading-zero suppression armed.
- Byte order: '-' (only if negative=1), then digits, then 0x0D, 0x0A (only if APPEND_CRLF=1).
  - Leading zeros are skipped. D0 is always sent, so value 0 sends "0".
  - negative=1 with value 0 sends "-0"; no normalisation.
  - Digit byte = 0x30 + digit.
- LOAD: select the next byte (sign, digit, or terminator) into tx_data, or go to DONE if none remain. A skipped leading zero costs one LOAD cycle.
- ISSUE: if tx_busy=0, assert tx_start=1 for exactly one cycle and go to WAIT_HI. If tx_busy=1, hold with tx_start=0.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. The UART raises busy the cycle after start.
- WAIT_LO: wait for tx_busy=0, then go to LOAD.
- tx_data holds its value from LOAD until the next LOAD.
- DONE: done=1 for one cycle, then IDLE. busy drops in the IDLE cycle.
- Latency: start accepted at cycle T → busy=1 at T+1 → CONVERT T+1..T+16 → LOAD T+17 → first tx_start at T+18, provided tx_busy=0 and the first byte is not a suppressed zero.
- Maximum message length: 8 bytes ('-', 5 digits, CR, LF).
- Only one tx_start is issued per byte. tx_start is never high while tx_busy=1.

Test Plan:
- value=12345, negative=0, APPEND_CRLF=1 → tx_data sequence 0x31,0x32,0x33,0x34,0x35,0x0D,0x0A; 7 tx_start pulses; first at T+18; one done pulse after the 7th byte's tx_busy falls.
- value=0, negative=0 → 0x30,0x0D,0x0A only; exactly 3 tx_start pulses.
- value=65535, negative=1 → 0x2D,0x36,0x35,0x35,0x33,0x35,0x0D,0x0A; UART model serial line decodes "-65535\r\n" at 9600 baud.
- APPEND_CRLF=0, value=7 → single byte 0x37, then done; no 0x0D/0x0A emitted.
- tx_busy forced high before the first ISSUE → tx_start stays 0 until tx_busy falls, then pulses once. A second start during busy is ignored: message unchanged, no extra done.
- Assert reset during the 3rd byte of 12345 → tx_start=0, busy=0, done=0 immediately. After release, a new start with value=42 sends 0x34,0x32,0x0D,0x0A correctly.
